// File: rtl/calculator_top.sv
// Decimal keypad calculator: two unsigned operands of up to NDIG digits,
// add / subtract / multiply (repeated addition), eight 7-segment digits.
//
// Key handshake: there is no valid/ready pair. A key is "valid" in any
// cycle where cmd differs from the value sampled on the previous edge.
// The design is always "ready" in ENTER_A/ENTER_B/RESULT/ERROR. In
// ADD/SUB/MUL only clear-all is taken, and every other key is dropped.
module calculator_top #(
   parameter int NDIG = 8,
   parameter int W    = 27
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] cmd,
   output logic [6:0] displays [NDIG],
   output logic [1:0] status,
   output logic [2:0] EA,
   output logic [2:0] PE
);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_ADD     = 3'd2,
      S_SUB     = 3'd3,
      S_MUL     = 3'd4,
      S_RESULT  = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;

   localparam logic [W:0]   MAXV      = (W+1)'(99_999_999);
   localparam logic [W-1:0] DIG_LIMIT = W'(10_000_000);
   localparam logic [3:0]   K_NOP     = 4'hD;

   state_t     state_q, state_d;
   op_t        op_q, op_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, cnt_q, cnt_d, hold_q, hold_d;
   logic [3:0] prev_cmd_q, prev_cmd_d;
   logic [1:0] status_q, status_d;

   logic         key_new, is_digit, is_op, is_eq, is_clr;
   logic [W-1:0] dig_ext, a_ten, b_ten, disp_val;
   logic [W:0]   add_sum, mul_sum;
   op_t          cmd_op;

   // Binary to BCD by shift-and-add-3 over every input bit.
   function automatic logic [4*NDIG-1:0] to_bcd(input logic [W-1:0] v);
      logic [4*NDIG-1:0] bcd;
      bcd = '0;
      for (int i = W-1; i >= 0; i--) begin
         for (int j = 0; j < NDIG; j++) begin
            if (bcd[4*j +: 4] >= 4'd5) bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
         end
         bcd = {bcd[4*NDIG-2:0], v[i]};
      end
      return bcd;
   endfunction

   // BCD digit to {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Key decode and arithmetic shared by several states.
   always_comb begin
      key_new  = (cmd != prev_cmd_q);   // an X cmd makes this false
      is_digit = (cmd <= 4'd9);
      is_op    = (cmd == 4'hA) || (cmd == 4'hB) || (cmd == 4'hC);
      is_eq    = (cmd == 4'hE);
      is_clr   = (cmd == 4'hF);
      cmd_op   = (cmd == 4'hB) ? OP_SUB : (cmd == 4'hC) ? OP_MUL : OP_ADD;
      dig_ext  = {{(W-4){1'b0}}, cmd};
      a_ten    = (a_q << 3) + (a_q << 1) + dig_ext;
      b_ten    = (b_q << 3) + (b_q << 1) + dig_ext;
      add_sum  = {1'b0, a_q} + {1'b0, b_q};
      mul_sum  = {1'b0, r_q} + {1'b0, a_q};
   end

   // Value on the digits: operands while typing, R on a result, and the
   // last shown value frozen while a computation runs.
   always_comb begin
      case (state_q)
         S_ENTER_A: disp_val = a_q;
         S_ENTER_B: disp_val = b_q;
         S_RESULT:  disp_val = r_q;
         default:   disp_val = hold_q;
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      r_d        = r_q;
      cnt_d      = cnt_q;
      hold_d     = disp_val;
      prev_cmd_d = cmd;
      case (state_q)
         S_ENTER_A: begin
            if (key_new && is_digit && a_q < DIG_LIMIT) a_d = a_ten;
            else if (key_new && is_op) begin
               op_d    = cmd_op;
               b_d     = '0;
               state_d = S_ENTER_B;
            end
         end
         S_ENTER_B: begin
            if (key_new && is_digit && b_q < DIG_LIMIT) b_d = b_ten;
            else if (key_new && is_eq) begin
               case (op_q)
                  OP_SUB:  state_d = S_SUB;
                  OP_MUL:  state_d = S_MUL;
                  default: state_d = S_ADD;
               endcase
               r_d   = '0;
               cnt_d = b_q;
            end
         end
         S_ADD: begin
            if (add_sum > MAXV) state_d = S_ERROR;
            else begin
               r_d     = add_sum[W-1:0];
               a_d     = add_sum[W-1:0];
               state_d = S_RESULT;
            end
         end
         S_SUB: begin
            if (a_q < b_q) state_d = S_ERROR;
            else begin
               r_d     = a_q - b_q;
               a_d     = a_q - b_q;
               state_d = S_RESULT;
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               a_d     = r_q;
               state_d = S_RESULT;
            end else if (mul_sum > MAXV) begin
               state_d = S_ERROR;
            end else begin
               r_d   = mul_sum[W-1:0];
               cnt_d = cnt_q - W'(1);
               if (cnt_q == W'(1)) begin
                  a_d     = mul_sum[W-1:0];
                  state_d = S_RESULT;
               end
            end
         end
         S_RESULT: begin
            if (key_new && is_digit) begin
               a_d     = dig_ext;
               state_d = S_ENTER_A;
            end else if (key_new && is_op) begin
               op_d    = cmd_op;
               b_d     = '0;
               state_d = S_ENTER_B;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: state_d = S_ENTER_A;
      endcase
      // Clear-all wins over everything, compute states included.
      if (key_new && is_clr) begin
         state_d = S_ENTER_A;
         op_d    = OP_ADD;
         a_d     = '0;
         b_d     = '0;
         r_d     = '0;
         cnt_d   = '0;
         hold_d  = '0;
      end
      case (state_d)
         S_ENTER_A, S_ENTER_B: status_d = 2'b00;
         S_RESULT:             status_d = 2'b10;
         S_ERROR:              status_d = 2'b11;
         default:              status_d = 2'b01;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_ENTER_A;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         prev_cmd_q <= K_NOP;
         status_q   <= 2'b00;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         r_q        <= r_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         prev_cmd_q <= prev_cmd_d;
         status_q   <= status_d;
      end
   end

   // Segment drive: leading zeros blanked, digit 0 always lit, "E" on error.
   always_comb begin
      logic [4*NDIG-1:0] bcd;
      logic              lead;
      bcd  = to_bcd(disp_val);
      lead = 1'b1;
      for (int j = NDIG-1; j >= 0; j--) begin
         if (j == 0 || bcd[4*j +: 4] != 4'd0) lead = 1'b0;
         displays[j] = lead ? 7'b0000000 : seg7(bcd[4*j +: 4]);
      end
      if (state_q == S_ERROR) begin
         for (int j = 1; j < NDIG; j++) displays[j] = 7'b0000000;
         displays[0] = 7'b1111001;
      end
   end

   assign status = status_q;
   assign EA     = state_q;
   assign PE     = state_d;

endmodule

// File: tb/tb_calculator_top.sv
// Bench for calculator_top: directed key sequences followed by random keys,
// each checked against an arithmetic model of the calculator.
module tb_calculator_top;

   localparam longint unsigned MAXV = 64'd99_999_999;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] cmd   = 4'hD;
   logic [6:0] displays [8];
   logic [1:0] status;
   logic [2:0] EA;
   logic [2:0] PE;

   int n_cmp = 0;
   int n_err = 0;

   // Model: mode 0 typing A, 1 typing B, 2 result, 3 error.
   longint unsigned m_a, m_b, m_r;
   logic [3:0]      m_op;
   int              m_mode;

   logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

   calculator_top #(.NDIG(8), .W(27)) dut (
      .clock    (clock),
      .reset    (reset),
      .cmd      (cmd),
      .displays (displays),
      .status   (status),
      .EA       (EA),
      .PE       (PE)
   );

   // Clock
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [55:0] pack_disp();
      logic [55:0] p;
      for (int i = 0; i < 8; i++) p[7*i +: 7] = displays[i];
      return p;
   endfunction

   function automatic logic [55:0] exp_disp();
      logic [55:0]     p;
      longint unsigned t;
      p = '0;
      if (m_mode == 3) begin
         p[6:0] = 7'b1111001;
         return p;
      end
      t = (m_mode == 0) ? m_a : (m_mode == 1) ? m_b : m_r;
      for (int i = 0; i < 8; i++) begin
         if (i == 0 || t != 0) p[7*i +: 7] = seg_tab[t % 10];
         t = t / 10;
      end
      return p;
   endfunction

   function automatic logic [2:0] exp_ea();
      case (m_mode)
         0:       return 3'd0;
         1:       return 3'd1;
         2:       return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   function automatic logic [1:0] exp_status();
      case (m_mode)
         2:       return 2'b10;
         3:       return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Busy cycles the equals key would cost from the current model state.
   function automatic int eq_busy();
      if (m_mode != 1) return 0;
      if (m_op != 4'hC) return 1;
      if (m_a * m_b > MAXV) return int'(MAXV / m_a + 1);
      return (m_b == 0) ? 1 : int'(m_b);
   endfunction

   task automatic model_clear();
      m_a = 0; m_b = 0; m_r = 0; m_op = 4'hA; m_mode = 0;
   endtask

   task automatic model_key(input logic [3:0] k, output int busy);
      longint unsigned res;
      bit bad;
      busy = 0;
      if (k == 4'hF) begin
         model_clear();
         return;
      end
      if (k == 4'hD || m_mode == 3) return;
      case (m_mode)
         0: begin
            if (k <= 4'd9) begin
               if (m_a < 10_000_000) m_a = m_a * 10 + k;
            end else if (k >= 4'hA && k <= 4'hC) begin
               m_op = k; m_b = 0; m_mode = 1;
            end
         end
         1: begin
            if (k <= 4'd9) begin
               if (m_b < 10_000_000) m_b = m_b * 10 + k;
            end else if (k == 4'hE) begin
               busy = eq_busy();
               bad  = 1'b0;
               res  = 0;
               case (m_op)
                  4'hB: begin bad = (m_a < m_b); if (!bad) res = m_a - m_b; end
                  4'hC: begin res = m_a * m_b; bad = (res > MAXV); end
                  default: begin res = m_a + m_b; bad = (res > MAXV); end
               endcase
               if (bad) m_mode = 3;
               else begin
                  m_r = res; m_a = res; m_mode = 2;
               end
            end
         end
         default: begin
            if (k <= 4'd9) begin
               m_a = k; m_mode = 0;
            end else if (k >= 4'hA && k <= 4'hC) begin
               m_op = k; m_b = 0; m_mode = 1;
            end
         end
      endcase
   endtask

   task automatic check_state(input string where);
      check({where, " EA"},     EA,          exp_ea());
      check({where, " PE"},     PE,          exp_ea());
      check({where, " status"}, status,      exp_status());
      check({where, " disp"},   pack_disp(), exp_disp());
   endtask

   // Driver: called at a falling edge; presses one key, rides out any
   // computation, holds, then checks the settled outputs.
   task automatic press(input logic [3:0] k, input int hold, input bit inject);
      int busy;
      int n;
      if (k == cmd) begin
         cmd = 4'hD;
         @(negedge clock);
      end
      model_key(k, busy);
      cmd = k;
      if (busy > 0) begin
         n = 0;
         @(negedge clock);
         while (status == 2'b01 && n < 600) begin
            n++;
            if (n == 1 && inject) cmd = 4'($urandom_range(0, 9));
            @(negedge clock);
         end
         check("busy_cycles", n, busy);
      end
      repeat (hold) @(negedge clock);
      check_state("key");
   endtask

   task automatic press_seq(input logic [3:0] ks [$]);
      foreach (ks[i]) press(ks[i], 10, 1'b0);
   endtask

   initial begin
      logic [3:0] k;
      int         r;
      model_clear();

      // Reset
      reset = 1'b1;
      cmd   = 4'hD;
      repeat (3) @(negedge clock);
      check_state("reset");
      reset = 1'b0;
      @(negedge clock);
      check_state("post_reset");

      // 12 * 3 = 36, with the digit patterns spelled out
      press_seq('{4'd1, 4'd2, 4'hC, 4'd3, 4'hE});
      check("res36 d1", displays[1], 7'b1001111);
      check("res36 d0", displays[0], 7'b1111101);
      check("res36 d2", displays[2], 7'b0000000);

      // Chain from a result: 36 + 4 = 40
      press_seq('{4'hA, 4'd4, 4'hE});
      // New entry from a result: 5 + 7 = 12
      press_seq('{4'd5, 4'hA, 4'd7, 4'hE});
      // Repeated digit separated by NOP gives 11
      press_seq('{4'd1, 4'hD, 4'd1});
      // Negative subtraction -> error, then clear
      press_seq('{4'hF, 4'd3, 4'hB, 4'd5, 4'hE});
      press_seq('{4'd7, 4'hA, 4'hF});
      // Nine 9s (ninth ignored) + 1 -> overflow
      press_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
      press_seq('{4'hA, 4'd1, 4'hE, 4'hF});
      // Multiply by zero; multiply overflow part-way through
      press_seq('{4'd4, 4'hC, 4'd0, 4'hE, 4'hF});
      press_seq('{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hC, 4'd5, 4'hE, 4'hF});

      // Clear while a multiply is running
      press_seq('{4'd1, 4'hC, 4'd5, 4'd0});
      cmd = 4'hE;
      @(negedge clock);
      check("mul_running status", status, 2'b01);
      cmd = 4'hF;
      @(negedge clock);
      model_clear();
      check_state("clear_in_mul");

      // Asynchronous reset asserted mid-cycle
      press_seq('{4'd8, 4'hA});
      cmd = 4'hD;
      #2 reset = 1'b1;
      #1;
      model_clear();
      check("async_reset EA", EA, 3'd0);
      check("async_reset status", status, 2'b00);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_state("after_async_reset");

      // Random keys
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 50)      k = 4'($urandom_range(0, 9));
         else if (r < 65) k = 4'(4'hA + $urandom_range(0, 2));
         else if (r < 82) k = 4'hE;
         else if (r < 94) k = 4'hD;
         else             k = 4'hF;
         if (k == 4'hE && eq_busy() > 100) k = 4'hF;
         press(k, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/calculator_top.md
Name: calculator_top

Overview:
- Top level of a decimal 4-function-style keypad calculator: add, subtract, multiply.
- Consumes a 4-bit key command, accumulates two unsigned decimal operands and runs the selected operation.
- Drives eight 7-segment digits, a 2-bit status code, and the current and next FSM state for debug.

Parameters:
- NDIG, 8, number of decimal display digits and maximum operand length.
- W, 27, internal binary operand/result width (holds 99,999,999).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  key code: 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 NOP, 1110 equals, 1111 clear-all.
- displays  out  unpacked [7:0] of 7 bits  segment patterns.
  - displays[0] is the rightmost (least significant) digit.
  - Bit order {g,f,e,d,c,b,a}, active-high.
- status  out  2  00 entering, 01 busy, 10 result valid, 11 error.
- EA  out  3  current FSM state.
- PE  out  3  next FSM state (combinational).

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state ENTER_A (0); A=B=0; op=add; prev_cmd=1101; status 00.
  - displays[0]=0111111 ("0"); displays[7:1]=0000000 (blank).
- Key acceptance:
  - cmd is sampled every cycle into prev_cmd.
  - A key is accepted only in a cycle where cmd != prev_cmd (change detection), so a held key counts once.
  - Repeated identical keys need an intervening 1101 (NOP is never an action).
  - Unknown/X cmd counts as no change.
- FSM states (EA encoding):
  - 0 ENTER_A, 1 ENTER_B, 2 ADD, 3 SUB, 4 MUL, 5 RESULT, 6 ERROR.
  - Code 7 is unused and maps to ENTER_A.
- ENTER_A:
  - Digit d: A = A*10 + d, ignored if A already has 8 digits.
  - Operator: store op, B=0, go to ENTER_B.
  - Equals: ignored.
- ENTER_B:
  - Digit: B = B*10 + d, same 8-digit limit.
  - Equals: go to ADD, SUB or MUL per op.
  - Operator: ignored.
- ADD / SUB:
  - One cycle; R = A+B or A-B.
  - Next state RESULT, or ERROR if the result is negative or > 99,999,999.
- MUL:
  - Repeated addition: R starts at 0 and adds A once per cycle, with counter = B, while counter > 0.
  - Go to RESULT when counter reaches 0; B=0 yields R=0 after one cycle.
  - Go to ERROR the cycle the partial sum exceeds 99,999,999.
- RESULT:
  - Shows R; A := R.
  - Digit: A = d (new entry), go to ENTER_A.
  - Operator: chain with A=R, go to ENTER_B.
  - Equals: ignored.
- ERROR:
  - All digits show segment pattern 1111001 ("E") in displays[0] only, others blank.
  - Only 1111 is accepted.
- Clear-all (1111), accepted in any state including compute states: same values as reset, on the next edge.
- Keys arriving while in ADD/SUB/MUL are dropped; prev_cmd still updates.
- Status mapping:
  - 00 in ENTER_A/ENTER_B.
  - 01 in ADD/SUB/MUL.
  - 10 in RESULT.
  - 11 in ERROR.
- Display source:
  - ENTER_A shows A; ENTER_B shows B; ADD/SUB/MUL hold the last displayed value; RESULT shows R.
  - Binary to BCD via combinational double-dabble; leading zeros blanked; value 0 shows single "0".
- Segment codes:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- PE is the combinational next-state; EA is registered PE.

Test Plan:
- Reset pulse -> EA=0, PE=0, status=00, displays[0]=0111111, displays[7:1]=0.
- Keys 1,2,1100,3,1110, each held 10 cycles:
  - Display 1, then 12; after 1100, EA=1 and the display shows 0.
  - After 3, the display shows 3.
  - After 1110: EA=4 for 3 cycles with status 01, then EA=5, status 10, displays[1]=1001111 ("3"), displays[0]=1111101 ("6").
- Keys 5,1010,7,1110 -> result 12, status 10.
- Keys 1,1101,1 -> A=11 (NOP separates the repeats).
- Keys 3,1011,5,1110 -> EA=6, status 11, "E".
  - Then 1111 -> EA=0, display "0", status 00.
- Keys 9 ×8 (with NOPs),1010,1,1110 -> overflow -> status 11.
- Chain: after result 36, keys 1010,4,1110 -> 40.
